// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared execute-stage types and widths
// Purpose: common datapath width, multiplier FSM state type and counter width.
// Ports: none (package).
package cpu_pkg;

   localparam int WORD_WIDTH = 18;
   localparam int MUL_CNT_W  = $clog2(WORD_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell
// Purpose: single-bit sum/carry cell used to build ripple chains.
// Ports:
//   a, b  : input addend bits
//   c_in  : carry in
//   s     : sum bit
//   c_out : carry out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);

   assign s     = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/ripple_adder.sv
// rtl/ripple_adder.sv - WIDTH-bit ripple-carry adder built from full_adder cells
// Purpose: unsigned add with carry in and carry out.
// Ports:
//   a, b  : WIDTH-bit addends
//   c_in  : carry into bit 0
//   s     : WIDTH-bit sum
//   c_out : carry out of the top bit
module ripple_adder
   import cpu_pkg::*;
#(
   parameter int WIDTH = WORD_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] s,
   output logic             c_out
);

   logic [WIDTH:0] carry;

   assign carry[0] = c_in;
   assign c_out    = carry[WIDTH];

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder u_fa (
         .a     (a[i]),
         .b     (b[i]),
         .c_in  (carry[i]),
         .s     (s[i]),
         .c_out (carry[i+1])
      );
   end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - unsigned shift-and-add sequential multiplier
// Purpose: multiplies two WIDTH-bit unsigned operands, one partial product
// per clock, WIDTH steps per operation, with a start/busy/done handshake.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : synchronous active-low reset
//   start   : operation request, honoured only in IDLE or DONE
//   a, b    : multiplicand / multiplier, latched on an accepted start
//   busy    : high while the operation is stepping
//   done    : one-cycle pulse when product has just been updated
//   product : 2*WIDTH-bit result, held until the next completion
module seq_multiplier
   import cpu_pkg::*;
#(
   parameter int WIDTH = WORD_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   mul_state_t       state, state_d;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;   // also collects the low half of the product
   logic [WIDTH-1:0] acc_hi;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] sum;
   logic             c;
   logic             accept;
   logic             last;

   assign addend = mplier[0] ? mcand : '0;
   assign accept = start && (state == IDLE || state == DONE);
   assign last   = (state == RUN) && (cnt == LAST_STEP);

   ripple_adder #(.WIDTH(WIDTH)) u_adder (
      .a     (acc_hi),
      .b     (addend),
      .c_in  (1'b0),
      .s     (sum),
      .c_out (c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The carry is shifted into the top of acc_hi so it is never lost;
   // the sum LSB drops into the top of mplier as the next product bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand   <= '0;
         mplier  <= '0;
         acc_hi  <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (accept) begin
         mcand  <= a;
         mplier <= b;
         acc_hi <= '0;
         cnt    <= '0;
      end else if (state == RUN) begin
         acc_hi <= {c, sum[WIDTH-1:1]};
         mplier <= {sum[0], mplier[WIDTH-1:1]};
         cnt    <= cnt + 1'b1;
         if (last) begin
            product <= {c, sum, mplier[WIDTH-1:1]};
         end
      end
   end

   // Decoded straight from the state register, so both are registered.
   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Unsigned shift-and-add multiplier for the 18-bit datapath; consumes the one-bit-per-cell sums of a full_adder ripple chain, one partial product per clock.
- Sits beside the ALU in the execute stage and serves MUL instructions.
- Start/busy/done handshake to the control unit; the full-width product is held until the next operation.

Parameters:
- WIDTH, 18, operand width in bits; product is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  multiplicand, latched on accepted start
- b  input  WIDTH  multiplier, latched on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; product valid
- product  output  2*WIDTH  result register, held until the next completion

Behaviour:
- Reset, sampled at a rising clk edge with rst_n=0:
  - state=IDLE, busy=0, done=0, product=0, internal registers=0.
  - Reset mid-RUN aborts the operation: no done pulse, product=0.
- States:
  - IDLE: start=1 -> RUN. Latch mcand=a and mplier=b; acc_hi=0; cnt=0.
  - RUN: one step per edge (below); cnt++. On the step where cnt==WIDTH-1, go to DONE and write product.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back, no bubble). Otherwise go to IDLE.
- RUN step, combinational within the cycle:
  - {c, sum} = acc_hi + (mplier[0] ? mcand : 0), a WIDTH-bit ripple add with carry-out c.
  - Register update: {acc_hi, mplier} <= {c, sum, mplier} >> 1, over 2*WIDTH+1 bits, keeping the low 2*WIDTH.
  - mplier doubles as the low product half.
- Completion: product <= {acc_hi, mplier} after the final step.
- Latency: start sampled at edge N -> done=1 and new product visible in the cycle after edge N+WIDTH (WIDTH=18: done on cycle 19). Fixed latency, no early exit for zero operands.
- busy: 1 in RUN only.
- start in RUN is ignored; a and b are not re-sampled.
- Operand changes after the start edge have no effect.
- Arithmetic: unsigned; the product never overflows 2*WIDTH bits. Carry out of the ripple add is retained via the shift, never dropped.
- Outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package cpu_pkg:
  - WORD_WIDTH=18
  - mul_state_t enum {IDLE, RUN, DONE}
  - MUL_CNT_W=$clog2(WORD_WIDTH)
- One sub-module: ripple_adder
  - WIDTH-bit chain of full_adder instances.
  - Ports a, b, c_in, s, c_out.
  - c_in tied to 0 here.
- Counter, FSM and shift register stay in seq_multiplier.

Test Plan:
- Basic: a=3, b=5, start pulse -> busy for 18 cycles; done pulse on cycle 19; product=15; done low the following cycle.
- Maximum: a=b=0x3FFFF -> product=0xF_FFF8_0001. Exercises the carry-out path on every step.
- Zero and identity:
  - a=0, b=0x2AAAA -> product=0, still 18-cycle latency.
  - a=1, b=0x12345 -> product=0x12345.
- start held high in RUN, with a and b changed mid-operation -> ignored; first result unaffected (7*9=63).
- Back-to-back: start=1 in the DONE cycle with a=0x100, b=0x200 -> no IDLE cycle; second done 19 cycles later; product=0x20000.
- rst_n=0 for one edge at cycle 10 of a=0x3FFFF, b=2 -> busy=0, product=0, no done pulse. A subsequent start with a=6, b=7 yields 42.
